stream_narrow_packer: RTL and testbench

- Sits directly downstream of the HyperSpace core's 16-bit output stream, before the user-project GPIO pads.
- Buffers 16-bit words with `last` in a small FIFO and serializes each word into two 8-bit beats, high byte first, on a narrower ready/valid/last stream. This frees 8 mprj_io pins.
- Checks frame length against the expected spectrum size and flags violations.

---
 rtl/stream_narrow_packer.sv | 123 ++++++++++++
 tb/tb_stream_narrow_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_narrow_packer.sv
// stream_narrow_packer
//   Buffers 16-bit words (with frame `last`) in a small FIFO and serializes
//   each word as two 8-bit beats, high byte first, on a ready/valid/last
//   byte stream. Also checks the input frame length and keeps a frame count.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   in_valid/in_ready     : upstream word handshake (in_data[15:0], in_last)
//   out_valid/out_ready   : downstream byte handshake (out_data[7:0], out_last)
//   frame_err             : sticky frame-length error, cleared only by reset
//   frame_cnt[CNT_W-1:0]  : frames accepted on the input (wraps)
module stream_narrow_packer #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 1536,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(FRAME_LEN);
  localparam logic [WCW-1:0] LAST_IDX = WCW'(FRAME_LEN - 1);

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             sel_q, sel_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic   full, empty, push, beat, pop, at_last;
  entry_t head;

  always_comb begin
    // Extra pointer MSB tells full (MSBs differ) from empty (equal).
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty   = (wr_ptr_q == rd_ptr_q);
    head    = mem_q[rd_ptr_q[AW-1:0]];
    // in_ready comes from registered state only: a slot freed by this
    // cycle's pop is not offered until the next cycle.
    push    = in_valid && !full && !reset;
    beat    = !empty && out_ready;
    pop     = beat && sel_q;
    at_last = (word_cnt_q == LAST_IDX);

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sel_d       = sel_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = frame_err_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{last: in_last, data: in_data};
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (in_last) begin
        if (!at_last) frame_err_d = 1'b1;
        word_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end else if (at_last) begin
        // Expected last missing: flag and resync so the next word is index 0.
        frame_err_d = 1'b1;
        word_cnt_d  = '0;
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end

    if (beat) sel_d = !sel_q;
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sel_q       <= 1'b0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sel_q       <= sel_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage needs no reset: empty pointers mask stale contents.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign in_ready  = !full && !reset;
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : (sel_q ? head.data[7:0] : head.data[15:8]);
  assign out_last  = head.last && sel_q && !empty;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_stream_narrow_packer.sv
module tb_stream_narrow_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic        frame_err;
  logic [15:0] frame_cnt;

  stream_narrow_packer #(.DEPTH(4), .FRAME_LEN(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic       acc;
  logic       rnd_en = 1'b0;
  logic       mon_en = 1'b0;
  logic [8:0] exp_q [$];   // {last, byte} in expected output order

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: check each accepted byte, then record each accepted word.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {23'd0, out_last, out_data}, 32'h1ff);
        else begin
          chk("byte_order", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_data[15:8]});
        exp_q.push_back({in_last, in_data[7:0]});
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    acc = in_valid && in_ready;
    @(posedge clock);
    #1;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    chk("in_ready_in_reset", {31'd0, in_ready}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic iv; logic [15:0] id; logic il; logic ordy;
    logic e_ird; logic e_ov; logic [7:0] e_od; logic e_ol;
  } vec_t;
  vec_t tv [10];

  initial begin
    tv[0] = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[1] = '{1'b1, 16'h5678, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0};
    tv[2] = '{1'b1, 16'h9ABC, 1'b0, 1'b1, 1'b1, 1'b1, 8'h34, 1'b0};
    tv[3] = '{1'b1, 16'hDEF0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h56, 1'b0};
    tv[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h78, 1'b0};
    tv[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h9A, 1'b0};
    tv[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBC, 1'b0};
    tv[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'hDE, 1'b0};
    tv[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b1};
    tv[9] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    // Reset state
    do_reset();
    mon_en = 1'b1;
    @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data",  {24'd0, out_data}, 0);
    chk("rst_out_last",  {31'd0, out_last}, 0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_in_ready",  {31'd0, in_ready}, 1);
    @(posedge clock); #1;

    // Basic frame, table driven
    for (int i = 0; i < 10; i++) begin
      in_valid = tv[i].iv; in_data = tv[i].id; in_last = tv[i].il; out_ready = tv[i].ordy;
      @(negedge clock);
      chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tv[i].e_ird});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].e_ov});
      chk($sformatf("vec%0d_out_data", i),  {24'd0, out_data},  {24'd0, tv[i].e_od});
      chk($sformatf("vec%0d_out_last", i),  {31'd0, out_last},  {31'd0, tv[i].e_ol});
      @(posedge clock); #1;
    end
    chk("basic_frame_cnt", {16'd0, frame_cnt}, 1);
    chk("basic_frame_err", {31'd0, frame_err}, 0);

    // Backpressure: FIFO fills to exactly DEPTH words
    do_reset();
    begin
      int n;
      logic [15:0] w [6];
      for (int i = 0; i < 6; i++) w[i] = 16'hA0B0 + 16'(i * 16'h0101);
      n = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
        in_data = w[n]; in_last = (n == 3);
        tick();
        if (acc) n++;
      end
      chk("bp_accepted", n, 4);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clock);
      chk("bp_in_ready_full", {31'd0, in_ready}, 0);
      chk("bp_hold_data", {24'd0, out_data}, 32'hA0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("bp_hold_data2", {24'd0, out_data}, 32'hA0);
      @(posedge clock); #1;
      out_ready = 1'b1;
      tick(); // high byte
      @(negedge clock);
      chk("bp_in_ready_pop_cycle", {31'd0, in_ready}, 0);
      @(posedge clock); #1; // low byte, pop
      @(negedge clock);
      chk("bp_in_ready_after_pop", {31'd0, in_ready}, 1);
      @(posedge clock); #1;
      drain();
      chk("bp_frame_cnt", {16'd0, frame_cnt}, 1);
    end

    // Random out_ready over 3 frames
    do_reset();
    rnd_en = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) send_word(16'($urandom()), i == 3);
    drain();
    rnd_en = 1'b0; out_ready = 1'b0;
    chk("rnd_frame_cnt", {16'd0, frame_cnt}, 3);
    chk("rnd_frame_err", {31'd0, frame_err}, 0);

    // Short frame then a correct one
    do_reset();
    out_ready = 1'b1;
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    chk("short_err_before", {31'd0, frame_err}, 0);
    send_word(16'h3333, 1'b1);
    chk("short_err_set", {31'd0, frame_err}, 1);
    chk("short_frame_cnt", {16'd0, frame_cnt}, 1);
    for (int i = 0; i < 4; i++) send_word(16'h4440 + 16'(i), i == 3);
    chk("short_next_cnt", {16'd0, frame_cnt}, 2);
    chk("short_err_sticky", {31'd0, frame_err}, 1);
    drain();

    // Missing last
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_word(16'h5550 + 16'(i), 1'b0);
    chk("miss_err_before", {31'd0, frame_err}, 0);
    send_word(16'h5553, 1'b0);
    chk("miss_err_set", {31'd0, frame_err}, 1);
    chk("miss_frame_cnt0", {16'd0, frame_cnt}, 0);
    for (int i = 0; i < 4; i++) send_word(16'h6660 + 16'(i), i == 3);
    chk("miss_resync_cnt", {16'd0, frame_cnt}, 1);
    drain();

    // Reset after a high byte was accepted
    do_reset();
    out_ready = 1'b1;
    send_word(16'hC3D4, 1'b0);
    tick(); // high byte C3 accepted, low byte pending
    @(negedge clock);
    chk("mid_pending_low", {24'd0, out_data}, 32'hD4);
    @(posedge clock); #1;
    do_reset();
    @(negedge clock);
    chk("mid_out_valid", {31'd0, out_valid}, 0);
    chk("mid_frame_cnt", {16'd0, frame_cnt}, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    send_word(16'h5A6B, 1'b1);
    @(negedge clock);
    chk("mid_new_high", {24'd0, out_data}, 32'h5A);
    @(posedge clock); #1;
    drain();
    chk("mid_frame_err", {31'd0, frame_err}, 1); // word 0 with last: short frame

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
